sram_b_stream_ctrl: RTL and testbench
=====================================

# sram_b_stream_ctrl

Burst streaming controller that sits directly upstream of the banked `sram_b` memory wrappers and drives their 1-write/1-read port pair. It turns valid/ready burst commands into per-cycle SRAM port accesses with incrementing addresses. Read data returned on `Q1` one cycle after issue is buffered in a credit-controlled output FIFO, so downstream backpressure never drops a beat.

## Interface
- `ABITS`, 20, SRAM address width; matches the attached wrapper.
- `DBITS`, 8, SRAM data width and `WEM` width.
- `LBITS`, 16, burst length field width.
- `FIFO_DEPTH`, 4, read FIFO entries; power of two, at least 2.

Ports. One clock; reset is synchronous and active-high.
- `CLK` in 1: clock.
- `RST` in 1: synchronous active-high reset.
- `rd_cmd_valid` / `rd_cmd_ready`, in / out, 1: read command handshake.
- `rd_cmd_addr` in ABITS: first beat address.
- `rd_cmd_len` in LBITS: beats minus 1.
- `rd_data_valid` / `rd_data_ready`, out / in, 1: read data handshake.
- `rd_data` out DBITS: read beat.
- `rd_data_last` out 1: final beat of burst.
- `wr_cmd_valid` / `wr_cmd_ready`, in / out, 1: write command handshake.
- `wr_cmd_addr` in ABITS, `wr_cmd_len` in LBITS: same encoding as the read command.
- `wr_data_valid` / `wr_data_ready`, in / out, 1: write beat handshake.
- `wr_data` in DBITS, `wr_wem` in DBITS: write beat and bit mask.
- `wr_done` out 1: one-cycle pulse after a burst's last write.
- `CE0`, `WE0` out 1; `A0` out ABITS; `D0`, `WEM0` out DBITS: SRAM write port.
- `CE1` out 1; `A1` out ABITS: SRAM read port.
- `Q1` in DBITS: SRAM read data, valid one cycle after `CE1`.

## Operation
Read FSM has two states.
- `R_IDLE`: `rd_cmd_ready`=1. On handshake, latch the address and the remaining count (`len`), then go to `R_BURST`.
- `R_BURST`: issue a read (`CE1`=1, `A1`=addr) when `fifo_count + inflight < FIFO_DEPTH` and no write collision occurs. On issue, increment addr modulo 2^ABITS. After issuing with remaining count=0, return to `R_IDLE`.

Read return path:
- `inflight` is a 1-bit register set on issue. In the following cycle, `{Q1, last}` is pushed into the FIFO.
- `last` is captured at issue and is set when the remaining count was 0.
- The FIFO pops on `rd_data_valid && rd_data_ready`. A simultaneous push and pop leaves the count unchanged.

Write FSM has two states.
- `W_IDLE`: `wr_cmd_ready`=1. On handshake, go to `W_BURST`.
- `W_BURST`: `wr_data_ready`=1.
- On each `wr_data_valid`, drive combinationally `CE0`=`WE0`=1, `A0`=addr, `D0`=`wr_data`, `WEM0`=`wr_wem`, then increment addr.
- The last beat returns to `W_IDLE` and raises `wr_done` on the next cycle.

Port rules:
- SRAM port outputs are 0 whenever no access occurs.
- Collision: if a write and a read target the same address in the same cycle, the write proceeds and the read is held for that cycle (`CE1`=0, no address increment).
- Address wrap: `0xFFFFF` is followed by `0x00000`.
- `len`=0 is a single-beat burst.

Reset behaviour:
- `RST` forces both FSMs to idle, empties the FIFO, and clears `inflight`. A `Q1` return in the cycle after reset is discarded.
- Reset value of every output is 0, except `rd_cmd_ready`=1 and `wr_cmd_ready`=1.

## Timing
- Read, with cmd handshake at edge 0:
  - cycle 1: `CE1`=1.
  - cycle 2: `Q1` is valid and pushed.
  - cycle 3: `rd_data_valid`=1.
- Cmd-to-first-data latency is 3 cycles.
- Sustained read rate is 1 beat/cycle while `rd_data_ready`=1 and `FIFO_DEPTH`≥4.
- Credit check uses the registered count (no same-cycle pop credit).
- Write: zero latency from data handshake to the SRAM port. `wr_done` follows the last beat by 1 cycle.
- A new command is accepted no earlier than the cycle after the FSM returns to idle.

## Configuration
- `SRAM_B_STREAM_WR_EN` defined: write channel and collision check compiled in.
- Undefined:
  - `wr_cmd_ready`, `wr_data_ready`, `wr_done`, `CE0`, `WE0`, `A0`, `D0` and `WEM0` are tied to 0.
  - `wr_*` inputs are ignored.
  - Reads never stall for collision.

## Test plan
- Read addr=0x00010, len=3, `rd_data_ready`=1:
  - `CE1` high for cycles 1–4 with `A1`=0x10..0x13.
  - `rd_data` equals the preloaded values in cycles 3–6.
  - `rd_data_last` is asserted only in cycle 6.
- Read len=15 with `rd_data_ready` held low for 10 cycles:
  - at most 4 issues occur; the FIFO holds 4 beats.
  - After release, all 16 beats arrive in order with no loss or duplicate.
- Read addr=0xFFFFE, len=3: `A1` sequence is 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Write burst addr=0x100, len=1, data 0xA5/0x3C, `wem`=0xFF, with `wr_data_valid` gapped one cycle:
  - `CE0` pulses at both beats; `wr_done` pulses once, 1 cycle after the second beat.
  - A readback returns 0xA5 and 0x3C.
- Concurrent write and read both at 0x200 in the same cycle:
  - `CE0`=1 and `CE1`=0 that cycle.
  - The read issues the next cycle and returns the newly written data.
- Assert `RST` during a len=7 read with `inflight`=1:
  - outputs return to reset values.
  - no `rd_data_valid` appears afterwards.
  - A subsequent len=0 read returns exactly one beat with `last`=1.

Source files
------------

// File: rtl/sram_b_stream_ctrl.sv
// sram_b_stream_ctrl
// Burst streaming controller for the banked sram_b wrappers. Valid/ready
// burst commands become per-cycle SRAM accesses with incrementing addresses.
// Read data returning on Q1 one cycle after issue lands in a small FIFO.
// Reads are only issued when that FIFO has a free slot for them, so
// downstream backpressure never loses a beat.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   rd_cmd_*               read burst command (addr = first beat, len = beats-1)
//   rd_data_*              read beat stream with last-beat marker
//   wr_cmd_*               write burst command (same encoding as read)
//   wr_data_*, wr_wem      write beat stream and per-bit write mask
//   wr_done                one-cycle pulse after the last write beat of a burst
//   CE0/WE0/A0/D0/WEM0     SRAM write port
//   CE1/A1/Q1              SRAM read port (Q1 valid one cycle after CE1)
//
// Build option: define SRAM_B_STREAM_WR_EN to compile in the write channel and
// the write/read address collision check. Without it the write outputs are
// tied to 0 and the wr_* inputs are ignored.
module sram_b_stream_ctrl #(
    parameter int unsigned ABITS      = 20,
    parameter int unsigned DBITS      = 8,
    parameter int unsigned LBITS      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             rd_cmd_valid,
    output logic             rd_cmd_ready,
    input  logic [ABITS-1:0] rd_cmd_addr,
    input  logic [LBITS-1:0] rd_cmd_len,
    output logic             rd_data_valid,
    input  logic             rd_data_ready,
    output logic [DBITS-1:0] rd_data,
    output logic             rd_data_last,
    input  logic             wr_cmd_valid,
    output logic             wr_cmd_ready,
    input  logic [ABITS-1:0] wr_cmd_addr,
    input  logic [LBITS-1:0] wr_cmd_len,
    input  logic             wr_data_valid,
    output logic             wr_data_ready,
    input  logic [DBITS-1:0] wr_data,
    input  logic [DBITS-1:0] wr_wem,
    output logic             wr_done,
    output logic             CE0,
    output logic             WE0,
    output logic [ABITS-1:0] A0,
    output logic [DBITS-1:0] D0,
    output logic [DBITS-1:0] WEM0,
    output logic             CE1,
    output logic [ABITS-1:0] A1,
    input  logic [DBITS-1:0] Q1
);

    localparam int unsigned PBITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CBITS = PBITS + 1;

    typedef enum logic {R_IDLE, R_BURST} rd_state_t;

    rd_state_t        r_state, r_state_nx;
    logic [ABITS-1:0] r_addr;
    logic [LBITS-1:0] r_rem;
    logic             inflight, inflight_last;
    logic [DBITS:0]   fifo_mem [FIFO_DEPTH];
    logic [PBITS-1:0] wptr, rptr;
    logic [CBITS-1:0] fifo_count;
    logic             collision, credit_ok, issue, push, pop;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
`ifdef SRAM_B_STREAM_WR_EN
    typedef enum logic {W_IDLE, W_BURST} wr_state_t;

    wr_state_t        w_state, w_state_nx;
    logic [ABITS-1:0] w_addr;
    logic [LBITS-1:0] w_rem;
    logic             w_fire;

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_rem   <= '0;
            wr_done <= 1'b0;
        end else begin
            w_state <= w_state_nx;
            wr_done <= w_fire && (w_rem == '0);
            if (w_state == W_IDLE && wr_cmd_valid) begin
                w_addr <= wr_cmd_addr;
                w_rem  <= wr_cmd_len;
            end else if (w_fire) begin
                w_addr <= w_addr + ABITS'(1);
                w_rem  <= w_rem - LBITS'(1);
            end
        end
    end

    // Write beats go straight to the SRAM port in the handshake cycle.
    always_comb begin
        w_state_nx    = w_state;
        wr_cmd_ready  = 1'b0;
        wr_data_ready = 1'b0;
        w_fire        = 1'b0;
        CE0           = 1'b0;
        WE0           = 1'b0;
        A0            = '0;
        D0            = '0;
        WEM0          = '0;
        case (w_state)
            W_IDLE: begin
                wr_cmd_ready = 1'b1;
                if (wr_cmd_valid) w_state_nx = W_BURST;
            end
            W_BURST: begin
                wr_data_ready = 1'b1;
                if (wr_data_valid) begin
                    w_fire = 1'b1;
                    CE0    = 1'b1;
                    WE0    = 1'b1;
                    A0     = w_addr;
                    D0     = wr_data;
                    WEM0   = wr_wem;
                    if (w_rem == '0) w_state_nx = W_IDLE;
                end
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    // Same-address write and read in one cycle: the write wins, the read waits.
    assign collision = w_fire && (w_addr == r_addr);
`else
    logic unused_wr;
    assign unused_wr     = ^{wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
                             wr_data_valid, wr_data, wr_wem};
    assign wr_cmd_ready  = 1'b0;
    assign wr_data_ready = 1'b0;
    assign wr_done       = 1'b0;
    assign CE0           = 1'b0;
    assign WE0           = 1'b0;
    assign A0            = '0;
    assign D0            = '0;
    assign WEM0          = '0;
    assign collision     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    // Credit uses the registered FIFO count plus the beat still in flight;
    // a same-cycle pop does not free a slot for this cycle's issue.
    assign credit_ok = (fifo_count + CBITS'(inflight)) < CBITS'(FIFO_DEPTH);
    assign issue     = (r_state == R_BURST) && credit_ok && !collision;
    assign push      = inflight;
    assign pop       = rd_data_valid && rd_data_ready;

    assign CE1 = issue;
    assign A1  = issue ? r_addr : '0;

    assign rd_data_valid            = (fifo_count != '0);
    assign {rd_data_last, rd_data}  = rd_data_valid ? fifo_mem[rptr] : '0;

    always_comb begin
        r_state_nx   = r_state;
        rd_cmd_ready = 1'b0;
        case (r_state)
            R_IDLE: begin
                rd_cmd_ready = 1'b1;
                if (rd_cmd_valid) r_state_nx = R_BURST;
            end
            R_BURST: begin
                if (issue && r_rem == '0) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= R_IDLE;
            r_addr        <= '0;
            r_rem         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wptr          <= '0;
            rptr          <= '0;
            fifo_count    <= '0;
        end else begin
            r_state       <= r_state_nx;
            inflight      <= issue;
            inflight_last <= issue && (r_rem == '0);
            if (r_state == R_IDLE && rd_cmd_valid) begin
                r_addr <= rd_cmd_addr;
                r_rem  <= rd_cmd_len;
            end else if (issue) begin
                r_addr <= r_addr + ABITS'(1);
                r_rem  <= r_rem - LBITS'(1);
            end
            if (push) wptr <= wptr + PBITS'(1);
            if (pop)  rptr <= rptr + PBITS'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CBITS'(1);
                2'b01:   fifo_count <= fifo_count - CBITS'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by fifo_count.
    always_ff @(posedge CLK) begin
        if (!RST && push) fifo_mem[wptr] <= {inflight_last, Q1};
    end

endmodule

// File: tb/tb_sram_b_stream_ctrl.sv
// Self-checking bench for sram_b_stream_ctrl: directed scenarios plus random
// bursts against a reference memory and expected address/beat queues.
// Works with or without SRAM_B_STREAM_WR_EN defined.
module tb_sram_b_stream_ctrl;

    localparam int unsigned ABITS      = 20;
    localparam int unsigned DBITS      = 8;
    localparam int unsigned LBITS      = 16;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef SRAM_B_STREAM_WR_EN
    localparam bit WR = 1'b1;
`else
    localparam bit WR = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             rd_cmd_valid = 1'b0, rd_cmd_ready;
    logic [ABITS-1:0] rd_cmd_addr = '0;
    logic [LBITS-1:0] rd_cmd_len = '0;
    logic             rd_data_valid, rd_data_ready = 1'b0, rd_data_last;
    logic [DBITS-1:0] rd_data;
    logic             wr_cmd_valid = 1'b0, wr_cmd_ready;
    logic [ABITS-1:0] wr_cmd_addr = '0;
    logic [LBITS-1:0] wr_cmd_len = '0;
    logic             wr_data_valid = 1'b0, wr_data_ready, wr_done;
    logic [DBITS-1:0] wr_data = '0, wr_wem = '0;
    logic             CE0, WE0, CE1;
    logic [ABITS-1:0] A0, A1;
    logic [DBITS-1:0] D0, WEM0;
    logic [DBITS-1:0] Q1 = '0;

    always #5 CLK = ~CLK;

    sram_b_stream_ctrl #(
        .ABITS(ABITS), .DBITS(DBITS), .LBITS(LBITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .rd_data(rd_data), .rd_data_last(rd_data_last),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .wr_data(wr_data), .wr_wem(wr_wem), .wr_done(wr_done),
        .CE0(CE0), .WE0(WE0), .A0(A0), .D0(D0), .WEM0(WEM0),
        .CE1(CE1), .A1(A1), .Q1(Q1)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Preloaded SRAM contents are a fixed function of the address.
    function automatic logic [7:0] init_val(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h5};
    endfunction

    logic [7:0] sram    [logic [19:0]];
    logic [7:0] ref_mem [logic [19:0]];

    function automatic logic [7:0] sram_rd(input logic [19:0] a);
        return sram.exists(a) ? sram[a] : init_val(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // SRAM macro model: masked write, registered read.
    always @(posedge CLK) begin
        if (CE0 && WE0) sram[A0] = (sram_rd(A0) & ~WEM0) | (D0 & WEM0);
        if (CE1) Q1 <= sram_rd(A1);
    end

    // Expected read addresses and beats, in order.
    logic [19:0] exp_a [$];
    logic [8:0]  exp_d [$];
    int unsigned outstanding = 0;
    int unsigned issue_cnt   = 0;

    always @(negedge CLK) begin
        if (!RST) begin
            if (CE1) begin
                check("credit", 64'(outstanding < FIFO_DEPTH), 1);
                if (exp_a.size() == 0) check("a1_extra", 0, 1);
                else                   check("a1", A1, exp_a.pop_front());
                issue_cnt++;
            end
            if (WR && CE0 && CE1) check("collide", 64'(A0 != A1), 1);
            if (rd_data_valid && rd_data_ready) begin
                if (exp_d.size() == 0) check("rd_extra", 0, 1);
                else                   check("rd_beat", {rd_data_last, rd_data}, exp_d.pop_front());
            end
            outstanding = outstanding + 32'(CE1) - 32'(rd_data_valid && rd_data_ready);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns one step after the handshake edge (cycle 1 of the burst).
    task automatic rd_cmd(input logic [19:0] addr, input logic [15:0] len);
        int unsigned n = 0;
        while (!rd_cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("rd_cmd_ready", rd_cmd_ready, 1);
        for (int unsigned i = 0; i <= 32'(len); i++) begin
            logic [19:0] a;
            a = addr + 20'(i);
            exp_a.push_back(a);
            exp_d.push_back({i == 32'(len), ref_rd(a)});
        end
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = addr;
        rd_cmd_len   = len;
        tick();
        rd_cmd_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int unsigned n = 0;
        while ((exp_d.size() != 0 || exp_a.size() != 0) && n < 2000) begin
            rd_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        rd_data_ready = 1'b1;
        check("drain", exp_d.size() + exp_a.size(), 0);
        tick();
        check("idle_valid", rd_data_valid, 0);
    endtask

`ifdef SRAM_B_STREAM_WR_EN
    logic [7:0] wq_d [$];
    logic [7:0] wq_m [$];

    task automatic wr_burst(input logic [19:0] addr, input logic [15:0] len, input bit gap);
        int unsigned n = 0;
        while (!wr_cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("wr_cmd_ready", wr_cmd_ready, 1);
        wr_cmd_valid = 1'b1;
        wr_cmd_addr  = addr;
        wr_cmd_len   = len;
        tick();
        wr_cmd_valid = 1'b0;
        for (int unsigned i = 0; i <= 32'(len); i++) begin
            logic [19:0] a;
            a = addr + 20'(i);
            if (gap && i > 0) begin
                wr_data_valid = 1'b0;
                @(negedge CLK);
                check("ce0_gap", CE0, 0);
                tick();
            end
            wr_data_valid = 1'b1;
            wr_data       = wq_d[i];
            wr_wem        = wq_m[i];
            @(negedge CLK);
            check("wr_rdy", wr_data_ready, 1);
            check("ce0", {CE0, WE0}, 2'b11);
            check("a0", A0, a);
            check("d0", D0, wq_d[i]);
            check("wem0", WEM0, wq_m[i]);
            check("wr_done_early", wr_done, 0);
            ref_mem[a] = (ref_rd(a) & ~wq_m[i]) | (wq_d[i] & wq_m[i]);
            tick();
        end
        wr_data_valid = 1'b0;
        @(negedge CLK);
        check("wr_done", wr_done, 1);
        check("ce0_idle", CE0, 0);
        tick();
        @(negedge CLK);
        check("wr_done_once", wr_done, 0);
        tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset values
        @(negedge CLK);
        check("rst_rd_cmd_ready", rd_cmd_ready, 1);
        check("rst_wr_cmd_ready", wr_cmd_ready, 64'(WR));
        check("rst_rd_out", {rd_data_valid, rd_data_last, rd_data}, 0);
        check("rst_rd_port", {CE1, A1}, 0);
        check("rst_wr_port", {CE0, WE0, A0, D0, WEM0}, 0);
        check("rst_wr_misc", {wr_data_ready, wr_done}, 0);
        tick();

`ifndef SRAM_B_STREAM_WR_EN
        // Write channel absent: inputs must have no effect.
        wr_cmd_valid  = 1'b1;
        wr_data_valid = 1'b1;
        wr_data       = 8'hFF;
        wr_wem        = 8'hFF;
        tick();
        @(negedge CLK);
        check("tie_wr", {wr_cmd_ready, wr_data_ready, wr_done, CE0, WE0, A0, D0, WEM0}, 0);
        tick();
        wr_cmd_valid  = 1'b0;
        wr_data_valid = 1'b0;
`endif

        // Basic read timing: addr 0x10, len 3
        rd_data_ready = 1'b1;
        rd_cmd(20'h00010, 16'd3);
        for (int unsigned c = 1; c <= 7; c++) begin
            @(negedge CLK);
            check("t1_ce1", CE1, 64'(c <= 4));
            check("t1_valid", rd_data_valid, 64'(c >= 3 && c <= 6));
            check("t1_last", rd_data_last, 64'(c == 6));
            tick();
        end
        check("t1_left", exp_d.size(), 0);

        // Backpressure: len 15 with ready low for 10 cycles
        begin
            int unsigned base;
            rd_data_ready = 1'b0;
            base = issue_cnt;
            rd_cmd(20'h00300, 16'd15);
            repeat (10) tick();
            check("t2_issues", issue_cnt - base, FIFO_DEPTH);
            check("t2_valid", rd_data_valid, 1);
            drain(1'b0);
        end

        // Address wrap
        rd_cmd(20'hFFFFE, 16'd3);
        drain(1'b0);

`ifdef SRAM_B_STREAM_WR_EN
        // Gapped write burst and readback
        wq_d = '{8'hA5, 8'h3C};
        wq_m = '{8'hFF, 8'hFF};
        wr_burst(20'h00100, 16'd1, 1'b1);
        rd_cmd(20'h00100, 16'd1);
        drain(1'b0);

        // Same-address write and read in the same cycle
        check("col_rdy", {rd_cmd_ready, wr_cmd_ready}, 2'b11);
        ref_mem[20'h00200] = 8'h77;
        exp_a.push_back(20'h00200);
        exp_d.push_back({1'b1, 8'h77});
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = 20'h00200;
        rd_cmd_len   = '0;
        wr_cmd_valid = 1'b1;
        wr_cmd_addr  = 20'h00200;
        wr_cmd_len   = '0;
        tick();
        rd_cmd_valid  = 1'b0;
        wr_cmd_valid  = 1'b0;
        wr_data_valid = 1'b1;
        wr_data       = 8'h77;
        wr_wem        = 8'hFF;
        @(negedge CLK);
        check("col_ce0", CE0, 1);
        check("col_ce1", CE1, 0);
        check("col_a0", A0, 20'h00200);
        tick();
        wr_data_valid = 1'b0;
        @(negedge CLK);
        check("col_ce1_next", CE1, 1);
        check("col_a1", A1, 20'h00200);
        check("col_wr_done", wr_done, 1);
        tick();
        drain(1'b0);
`endif

        // Reset in the middle of a len 7 read with a beat in flight
        rd_data_ready = 1'b0;
        rd_cmd(20'h00400, 16'd7);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_a.delete();
        exp_d.delete();
        outstanding = 0;
        @(negedge CLK);
        check("rr_rd_cmd_ready", rd_cmd_ready, 1);
        check("rr_wr_cmd_ready", wr_cmd_ready, 64'(WR));
        check("rr_rd_out", {rd_data_valid, rd_data_last, rd_data}, 0);
        check("rr_rd_port", {CE1, A1}, 0);
        tick();
        rd_data_ready = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            check("rr_no_valid", rd_data_valid, 0);
            tick();
        end
        rd_cmd(20'h00500, 16'd0);
        drain(1'b0);
        repeat (4) begin
            @(negedge CLK);
            check("rr_single", rd_data_valid, 0);
            tick();
        end

        // Random read bursts with random backpressure
        for (int k = 0; k < 12; k++) begin
            logic [19:0] a;
            a = ($urandom_range(0, 3) == 0) ? 20'hFFFF0 + 20'($urandom_range(0, 15))
                                            : 20'($urandom);
            rd_cmd(a, 16'($urandom_range(0, 20)));
            drain(1'b1);
        end

`ifdef SRAM_B_STREAM_WR_EN
        // Random masked write bursts, each read back
        for (int k = 0; k < 6; k++) begin
            logic [19:0] a;
            logic [15:0] l;
            a = 20'($urandom);
            l = 16'($urandom_range(0, 5));
            wq_d.delete();
            wq_m.delete();
            for (int unsigned i = 0; i <= 32'(l); i++) begin
                wq_d.push_back(8'($urandom));
                wq_m.push_back(8'($urandom));
            end
            wr_burst(a, l, 1'($urandom_range(0, 1)));
            rd_cmd(a, l);
            drain(1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
